// File: rtl/div_module_pkg.sv
// div_module_pkg: shared widths and FSM state type for the iterative divider.
//   DIV_WIDTH_A : dividend / quotient width
//   DIV_WIDTH_B : divisor width (sign-extended to DIV_WIDTH_A internally)
//   DIV_CNT_W   : iteration counter width, 2**DIV_CNT_W >= DIV_WIDTH_A
//   div_state_e : IDLE / RUN / DONE
package div_module_pkg;

  localparam int unsigned DIV_WIDTH_A = 32;
  localparam int unsigned DIV_WIDTH_B = 16;
  localparam int unsigned DIV_CNT_W   = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_module_if.sv
// div_module_if: operand / ctrl / RDY handshake shared with the multiplier.
//   data_operandA  : signed dividend            (master -> slave)
//   data_operandB  : signed divisor             (master -> slave)
//   ctrl_DIV       : start request              (master -> slave)
//   data_result    : signed quotient            (slave -> master)
//   data_exception : divide-by-zero / overflow  (slave -> master)
//   data_inputRDY  : idle, ready for ctrl_DIV   (slave -> master)
//   data_resultRDY : one-cycle result valid     (slave -> master)
interface div_module_if #(
  parameter int unsigned WIDTH_A = 32,
  parameter int unsigned WIDTH_B = 16
) ();

  logic [WIDTH_A-1:0] data_operandA;
  logic [WIDTH_B-1:0] data_operandB;
  logic               ctrl_DIV;
  logic [WIDTH_A-1:0] data_result;
  logic               data_exception;
  logic               data_inputRDY;
  logic               data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_DIV,
    input  data_result, data_exception, data_inputRDY, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_DIV,
    output data_result, data_exception, data_inputRDY, data_resultRDY
  );

endinterface

// File: rtl/div_module_step.sv
// div_step: one restoring-division iteration (combinational).
//   rem      : current partial remainder
//   dvd_bit  : next dividend bit shifted into the remainder
//   mag_b    : divisor magnitude
//   rem_next : remainder after the trial subtract / restore
//   q_bit    : quotient bit produced by this iteration
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_shift = {rem[WIDTH-2:0], dvd_bit};
    trial     = {1'b0, rem_shift} - {1'b0, mag_b};
    // A set rem MSB means the shifted value overflowed WIDTH bits and is
    // certainly >= mag_b; the low WIDTH bits of the difference stay exact.
    q_bit     = rem[WIDTH-1] | ~trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift;
  end

endmodule

// File: rtl/div_module.sv
// div_module: iterative signed divider, restoring algorithm, one quotient
// bit per cycle. Quotient truncates toward zero.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   div_bus : slave side of div_module_if (operands, ctrl_DIV, result, RDYs)
// A normal division takes 32 RUN cycles followed by a one-cycle DONE pulse;
// divide-by-zero and the -2^31 / -1 overflow go straight to DONE.
module div_module
  import div_module_pkg::*;
#(
  parameter int unsigned WIDTH_A = DIV_WIDTH_A,
  parameter int unsigned WIDTH_B = DIV_WIDTH_B,
  parameter int unsigned CNT_W   = DIV_CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  div_module_if.slave  div_bus
);

  div_state_e         state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_A-1:0] rem;
  logic [WIDTH_A-1:0] dvd;       // dividend shifts out, quotient shifts in
  logic [WIDTH_A-1:0] mag_b;
  logic               sign_q;
  logic [WIDTH_A-1:0] result_q;
  logic               exc_q;

  logic [WIDTH_A-1:0] a_in, b_ext, abs_a, abs_b;
  logic [WIDTH_A-1:0] rem_next, q_final, q_signed;
  logic               q_bit, start_exc, last_iter;

  always_comb begin
    a_in      = div_bus.data_operandA;
    b_ext     = {{(WIDTH_A-WIDTH_B){div_bus.data_operandB[WIDTH_B-1]}},
                 div_bus.data_operandB};
    abs_a     = a_in[WIDTH_A-1]  ? ('0 - a_in)  : a_in;
    abs_b     = b_ext[WIDTH_A-1] ? ('0 - b_ext) : b_ext;
    start_exc = (b_ext == '0) ||
                ((a_in == {1'b1, {(WIDTH_A-1){1'b0}}}) && (b_ext == '1));
    last_iter = (cnt == CNT_W'(WIDTH_A-1));
    q_final   = {dvd[WIDTH_A-2:0], q_bit};
    q_signed  = sign_q ? ('0 - q_final) : q_final;
  end

  div_step #(.WIDTH(WIDTH_A)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH_A-1]),
    .mag_b    (mag_b),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= DIV_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (div_bus.ctrl_DIV) state_next = start_exc ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (last_iter)        state_next = DIV_DONE;
      DIV_DONE:                       state_next = DIV_IDLE;
      default:                        state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      mag_b    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_bus.ctrl_DIV) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= abs_a;
            mag_b    <= abs_b;
            sign_q   <= a_in[WIDTH_A-1] ^ div_bus.data_operandB[WIDTH_B-1];
            result_q <= '0;
            exc_q    <= start_exc;
          end
        end
        DIV_RUN: begin
          rem <= rem_next;
          dvd <= q_final;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) result_q <= q_signed;
        end
        default: ;
      endcase
    end
  end

  assign div_bus.data_result    = result_q;
  assign div_bus.data_exception = exc_q;
  assign div_bus.data_inputRDY  = (state == DIV_IDLE);
  assign div_bus.data_resultRDY = (state == DIV_DONE);

endmodule

// File: tb/tb_div_module.sv
// tb_div_module: self-checking bench for div_module. A cycle-level reference
// model tracks when the divider is free, when each result is due and what the
// quotient must be (plain signed arithmetic); a negedge process compares the
// DUT against it every cycle. Directed cases pin the model with literals.
module tb_div_module;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  div_module_if #(.WIDTH_A(32), .WIDTH_B(16)) div_bus ();

  div_module #(.WIDTH_A(32), .WIDTH_B(16), .CNT_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .div_bus (div_bus)
  );

  int n_checks   = 0;
  int n_pass     = 0;
  int ecount     = 0;    // rising edges seen
  int next_free  = 0;    // first edge at which a start can be accepted
  int done_edge  = -1;   // edge after which resultRDY must be high
  int n_rdy      = 0;
  int last_rdy_e = -1;
  logic [31:0] pend_q = '0, held_q = '0, last_q = '0;
  logic        pend_x = 1'b0, held_x = 1'b0, last_x = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [31:0] q, output logic x);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0 || (a == 32'h8000_0000 && b == 16'hFFFF)) begin
      q = '0;
      x = 1'b1;
    end else begin
      t = sa / sb;
      q = t[31:0];
      x = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] s;
    s = 32'($urandom_range(0, 1000));
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return s;
      3:       return 32'd0 - s;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] rand_b();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h0001;
      3:       return 16'h8000;
      4:       return 16'(3 + $urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: decides acceptance and the due edge of each result.
  always @(posedge clock) begin
    logic [31:0] mq;
    logic        mx;
    ecount++;
    if (!reset_n) begin
      next_free = ecount + 1;
      done_edge = -1;
      held_q    = '0;
      held_x    = 1'b0;
    end else if (div_bus.ctrl_DIV && ecount >= next_free) begin
      model_div(div_bus.data_operandA, div_bus.data_operandB, mq, mx);
      pend_q    = mq;
      pend_x    = mx;
      done_edge = mx ? ecount : ecount + 32;
      next_free = done_edge + 2;
    end
  end

  // Compare process.
  always @(negedge clock) begin
    logic exp_in, exp_out;
    if (!reset_n) begin
      chk("rst_inputRDY",  64'(div_bus.data_inputRDY),  64'(1));
      chk("rst_resultRDY", 64'(div_bus.data_resultRDY), 64'(0));
      chk("rst_result",    64'(div_bus.data_result),    64'(0));
      chk("rst_exception", 64'(div_bus.data_exception), 64'(0));
    end else begin
      exp_in  = (ecount >= next_free - 1);
      exp_out = (ecount == done_edge);
      chk("inputRDY",  64'(div_bus.data_inputRDY),  64'(exp_in));
      chk("resultRDY", 64'(div_bus.data_resultRDY), 64'(exp_out));
      if (exp_out) begin
        chk("result",    64'(div_bus.data_result),    64'(pend_q));
        chk("exception", 64'(div_bus.data_exception), 64'(pend_x));
        held_q = pend_q;
        held_x = pend_x;
      end else if (exp_in) begin
        chk("held_result",    64'(div_bus.data_result),    64'(held_q));
        chk("held_exception", 64'(div_bus.data_exception), 64'(held_x));
      end
    end
    if (div_bus.data_resultRDY) begin
      n_rdy++;
      last_rdy_e = ecount;
      last_q     = div_bus.data_result;
      last_x     = div_bus.data_exception;
    end
  end

  task automatic start_div(input logic [31:0] a, input logic [15:0] b, output int start_e);
    int guard;
    guard = 0;
    while (ecount + 1 < next_free && guard < 100) begin
      @(negedge clock); #1;
      guard++;
    end
    chk("start_bound", 64'(guard < 100), 64'(1));
    div_bus.data_operandA = a;
    div_bus.data_operandB = b;
    div_bus.ctrl_DIV      = 1'b1;
    @(negedge clock); #1;
    start_e               = ecount;
    div_bus.ctrl_DIV      = 1'b0;
    div_bus.data_operandA = $urandom;
    div_bus.data_operandB = 16'($urandom);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (ecount < done_edge && guard < 60) begin
      @(negedge clock); #1;
      guard++;
    end
    chk("done_bound", 64'(guard < 60), 64'(1));
  endtask

  task automatic run_directed(input string name, input logic [31:0] a, input logic [15:0] b,
                              input logic [31:0] q, input logic x, input int lat);
    int s, r0;
    r0 = n_rdy;
    start_div(a, b, s);
    wait_done();
    chk({name, "_q"},   64'(last_q), 64'(q));
    chk({name, "_exc"}, 64'(last_x), 64'(x));
    chk({name, "_lat"}, 64'(last_rdy_e - s), 64'(lat));
    chk({name, "_rdy"}, 64'(n_rdy), 64'(r0 + 1));
  endtask

  initial begin
    int s, r0;
    div_bus.ctrl_DIV      = 1'b0;
    div_bus.data_operandA = '0;
    div_bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;

    run_directed("p100_7",   32'd100,         16'd7,      32'd14,          1'b0, 32);
    run_directed("m100_7",   32'hFFFF_FF9C,   16'd7,      32'hFFFF_FFF2,   1'b0, 32);
    run_directed("p100_m7",  32'd100,         16'hFFF9,   32'hFFFF_FFF2,   1'b0, 32);
    run_directed("m100_m7",  32'hFFFF_FF9C,   16'hFFF9,   32'd14,          1'b0, 32);
    run_directed("max_1",    32'h7FFF_FFFF,   16'd1,      32'h7FFF_FFFF,   1'b0, 32);
    run_directed("min_2",    32'h8000_0000,   16'd2,      32'hC000_0000,   1'b0, 32);
    run_directed("min_1",    32'h8000_0000,   16'd1,      32'h8000_0000,   1'b0, 32);
    run_directed("m7_2",     32'hFFFF_FFF9,   16'd2,      32'hFFFF_FFFD,   1'b0, 32);
    run_directed("div0",     32'd5,           16'd0,      32'd0,           1'b1, 0);
    run_directed("ovf",      32'h8000_0000,   16'hFFFF,   32'd0,           1'b1, 0);

    // Start request during RUN with new operands is ignored.
    r0 = n_rdy;
    start_div(32'd100, 16'd7, s);
    repeat (9) @(negedge clock);
    #1;
    div_bus.data_operandA = 32'd1234;
    div_bus.data_operandB = 16'd5;
    div_bus.ctrl_DIV      = 1'b1;
    @(negedge clock); #1;
    div_bus.ctrl_DIV      = 1'b0;
    wait_done();
    chk("ignore_mid_q",   64'(last_q), 64'(14));
    chk("ignore_mid_rdy", 64'(n_rdy),  64'(r0 + 1));

    // Reset mid-RUN aborts the division with no result pulse.
    r0 = n_rdy;
    start_div(32'd1000, 16'd7, s);
    repeat (14) @(negedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("abort_no_rdy", 64'(n_rdy), 64'(r0));
    run_directed("after_rst", 32'd9, 16'd3, 32'd3, 1'b0, 32);

    // ctrl_DIV held high: back-to-back starts, operands change every cycle.
    r0 = n_rdy;
    for (int i = 0; i < 700; i++) begin
      div_bus.ctrl_DIV      = 1'b1;
      div_bus.data_operandA = rand_a();
      div_bus.data_operandB = rand_b();
      @(negedge clock); #1;
    end
    // Sparse random requests.
    for (int i = 0; i < 3000; i++) begin
      div_bus.ctrl_DIV      = ($urandom_range(0, 9) == 0);
      div_bus.data_operandA = rand_a();
      div_bus.data_operandB = rand_b();
      @(negedge clock); #1;
    end
    div_bus.ctrl_DIV = 1'b0;
    repeat (40) @(negedge clock);
    #1;
    chk("random_activity", 64'(n_rdy > r0 + 50), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
